instruction_cache_assoc: RTL and testbench
==========================================

Name: instruction_cache_assoc

Overview:
Parametrised instruction cache between the fetch stage and the block-read port of instruction memory. Set count, ways (1 or 2), line length and cached address span are configurable. Adds what the fixed direct-mapped cache lacks: 2-way LRU replacement, a memory ready handshake (variable fill latency), a flush input for fence.i, and asynchronous reset. Shares the memory port with the data cache through data_cache_busy, as before.

Parameters:
WAYS, 2, associativity; legal values 1 or 2.
SETS, 8, sets; power of 2, at least 2.
LINE_WORDS, 8, 32-bit words per line; power of 2, at least 2.
ADDR_WIDTH, 14, cached byte-address bits; higher bits ignored.
Derived values:
- OFF_BITS = log2(LINE_WORDS).
- IDX_BITS = log2(SETS).
- TAG_BITS = ADDR_WIDTH-2-OFF_BITS-IDX_BITS; must be at least 1.
- LINE_BITS = 32*LINE_WORDS.
- BLK_BITS = ADDR_WIDTH-2-OFF_BITS.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
addr  in  32  fetch byte address.
out  out  32  fetched instruction.
clk_stall  out  1  stall the pipeline; out is invalid while high.
flush  in  1  invalidate all lines (fence.i).
mem_block_addr  out  BLK_BITS  line address to memory: addr[ADDR_WIDTH-1:2+OFF_BITS].
readmem  out  1  line read request; held until mem_ready.
mem_ready  in  1  new_line is valid this cycle.
new_line  in  LINE_BITS  fill data; word 0 in bits [31:0].
data_cache_busy  in  1  data cache owns memory; freezes the FSM unless readmem=1.

Behaviour:
- Address split: tag = addr[ADDR_WIDTH-1 : 2+OFF_BITS+IDX_BITS]; index = next IDX_BITS; word offset = addr[2+OFF_BITS-1:2].
- Reset (rst_n=0, asynchronous):
  - clk_stall=0, readmem=0, mem_block_addr=0.
  - addr_buf=0, line_buf=0, so out=0.
  - All valid bits=0, LRU bits=0, flush_pend=0, state=IDLE.
  - Reset during a miss drops readmem immediately; the fill is abandoned.
- Enable: the FSM advances only when (!data_cache_busy || readmem). Otherwise all registers hold.
- out is combinational: the word of line_buf selected by addr_buf's offset.
- IDLE, flush=1:
  - Clear all valid bits and LRU bits; clk_stall<=1; go to FLUSH.
  - flush takes priority over the lookup.
- IDLE, flush=0:
  - addr_buf<=addr.
  - Compare tag against every valid way of the indexed set.
  - Hit: line_buf<=hit line; clk_stall<=0; LRU[set]<=the way not hit (WAYS=2). out is valid the next cycle (1-cycle latency).
  - Miss: clk_stall<=1; readmem<=1; mem_block_addr<=block address; latch victim; go to MISS_WAIT.
  - Victim choice: the lowest-numbered invalid way, else the LRU way; way 0 when WAYS=1.
- MISS_WAIT, mem_ready=0: hold readmem=1, clk_stall=1 and mem_block_addr.
- MISS_WAIT, mem_ready=1:
  - Write new_line into the victim; set its valid bit and tag from addr_buf.
  - line_buf<=new_line; LRU[set]<=other way.
  - readmem<=0; clk_stall<=0; go to IDLE.
  - Minimum miss penalty: 2 cycles.
- flush in MISS_WAIT: sets flush_pend; the fill completes and its word is delivered. On entering IDLE with flush_pend=1, behave as flush=1 and clear flush_pend.
- FLUSH: clk_stall<=0; go to IDLE. The following lookup misses.
- mem_ready is ignored outside MISS_WAIT.
- Invariant: at most one way hits per lookup; the bench asserts this.

Decomposition:
- Package icache_pkg:
  - state enum (IDLE, MISS_WAIT, FLUSH).
  - log2 helper function.
  - Derived-width localparam functions.
- Sub-module icache_tag_store: per-set valid, tag and LRU storage; combinational hit, hit_way and victim outputs; write/update ports.
- Data array and FSM stay in the top module.

Test Plan:
1. Cold miss at addr=0x0000_0040: readmem=1, mem_block_addr=2; mem_ready 3 cycles later with word i = 0x100+i; stall clears -> out=0x100. Then addr=0x44 hits -> out=0x101, no stall.
2. WAYS=2: fill 0x0040, then 0x1040 (same set 2), then 0x2040 -> 0x0040 evicted (LRU). A re-fetch of 0x1040 hits; a re-fetch of 0x0040 misses.
3. flush in IDLE after 0x40 is cached: one stall cycle, then 0x40 misses with readmem=1.
4. flush during MISS_WAIT: fill data is delivered, then a FLUSH cycle, then the same address misses again.
5. data_cache_busy=1 in IDLE with a miss pending: no readmem and state frozen. With readmem=1, MISS_WAIT proceeds despite busy.
6. rst_n low mid-miss: readmem=0 and clk_stall=0 within the same cycle; after release every fetch misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MISS_WAIT = 2'd1,
      FLUSH     = 2'd2
   } state_e;

   function automatic int clog2_f(input int v);
      int r;
      r = 32'sd0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < v) begin
            r = i + 32'sd1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   function automatic int off_bits_f(input int line_words);
      return clog2_f(line_words);
   endfunction

   function automatic int idx_bits_f(input int sets);
      return clog2_f(sets);
   endfunction

   function automatic int tag_bits_f(input int addr_width, input int line_words, input int sets);
      return addr_width - 32'sd2 - clog2_f(line_words) - clog2_f(sets);
   endfunction

   function automatic int blk_bits_f(input int addr_width, input int line_words);
      return addr_width - 32'sd2 - clog2_f(line_words);
   endfunction

   function automatic int line_bits_f(input int line_words);
      return 32'sd32 * line_words;
   endfunction

endpackage

// File: rtl/icache_tag_store.sv
// Per-set valid/tag/LRU storage with combinational hit detection and victim choice.
module icache_tag_store
   import icache_pkg::*;
#(
   parameter  int WAYS     = 2,
   parameter  int SETS     = 8,
   parameter  int TAG_BITS = 6,
   localparam int IDX_BITS = idx_bits_f(SETS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IDX_BITS-1:0] lk_idx_i,
   input  logic [TAG_BITS-1:0] lk_tag_i,
   output logic                hit_o,
   output logic                hit_way_o,
   output logic                victim_o,
   input  logic                clear_i,
   input  logic                wr_en_i,
   input  logic [IDX_BITS-1:0] wr_idx_i,
   input  logic                wr_way_i,
   input  logic [TAG_BITS-1:0] wr_tag_i,
   input  logic                lru_en_i,
   input  logic [IDX_BITS-1:0] lru_idx_i,
   input  logic                lru_used_i
);

   logic [SETS-1:0]     valid_q [WAYS];
   logic [TAG_BITS-1:0] tag_q   [WAYS][SETS];
   logic [SETS-1:0]     lru_q;

   // Tag compare across all valid ways of the looked-up set
   always_comb begin
      hit_o     = 1'b0;
      hit_way_o = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][lk_idx_i] && (tag_q[w][lk_idx_i] == lk_tag_i)) begin
            hit_o     = 1'b1;
            hit_way_o = w[0];
         end else begin
            hit_o     = hit_o;
         end
      end
   end

   // Victim: lowest invalid way wins (descending scan), else the LRU way
   always_comb begin
      victim_o = (WAYS == 2) ? lru_q[lk_idx_i] : 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][lk_idx_i]) begin
            victim_o = w[0];
         end else begin
            victim_o = victim_o;
         end
      end
   end

   // Storage update: reset, flush clear, fill write and LRU touch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) begin
               tag_q[w][s] <= '0;
            end
         end
         lru_q <= '0;
      end else if (clear_i) begin
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
         end
         lru_q <= '0;
      end else begin
         if (wr_en_i) begin
            valid_q[wr_way_i][wr_idx_i] <= 1'b1;
            tag_q[wr_way_i][wr_idx_i]   <= wr_tag_i;
         end
         if (lru_en_i) begin
            lru_q[lru_idx_i] <= ~lru_used_i;
         end
      end
   end

endmodule

// File: rtl/instruction_cache_assoc.sv
// Set-associative instruction cache: lookup/miss/flush FSM plus line data array.
module instruction_cache_assoc
   import icache_pkg::*;
#(
   parameter  int WAYS       = 2,
   parameter  int SETS       = 8,
   parameter  int LINE_WORDS = 8,
   parameter  int ADDR_WIDTH = 14,
   localparam int OFF_BITS   = off_bits_f(LINE_WORDS),
   localparam int IDX_BITS   = idx_bits_f(SETS),
   localparam int TAG_BITS   = tag_bits_f(ADDR_WIDTH, LINE_WORDS, SETS),
   localparam int LINE_BITS  = line_bits_f(LINE_WORDS),
   localparam int BLK_BITS   = blk_bits_f(ADDR_WIDTH, LINE_WORDS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          addr,
   output logic [31:0]          out,
   output logic                 clk_stall,
   input  logic                 flush,
   output logic [BLK_BITS-1:0]  mem_block_addr,
   output logic                 readmem,
   input  logic                 mem_ready,
   input  logic [LINE_BITS-1:0] new_line,
   input  logic                 data_cache_busy
);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:2]   addr_buf_q, addr_buf_d;
   logic [LINE_BITS-1:0]    line_buf_q, line_buf_d;
   logic                    clk_stall_q, clk_stall_d;
   logic                    readmem_q, readmem_d;
   logic [BLK_BITS-1:0]     blk_q, blk_d;
   logic                    victim_q, victim_d;
   logic                    flush_pend_q, flush_pend_d;
   logic [LINE_BITS-1:0]    data_q [WAYS][SETS];

   logic                    en_s, flush_now_s, hit_s, hit_way_s, victim_s;
   logic                    clear_s, wr_en_s, lru_en_s, lru_used_s;
   logic [IDX_BITS-1:0]     lk_idx_s, fill_idx_s, lru_idx_s;
   logic [TAG_BITS-1:0]     lk_tag_s, fill_tag_s;
   logic                    unused_addr_s;

   assign lk_tag_s       = addr[ADDR_WIDTH-1 -: TAG_BITS];
   assign lk_idx_s       = addr[2+OFF_BITS +: IDX_BITS];
   assign fill_tag_s     = addr_buf_q[ADDR_WIDTH-1 -: TAG_BITS];
   assign fill_idx_s     = addr_buf_q[2+OFF_BITS +: IDX_BITS];
   assign unused_addr_s  = ^{addr[31:ADDR_WIDTH], addr[1:0]};
   assign en_s           = !data_cache_busy || readmem_q;
   assign flush_now_s    = flush || flush_pend_q;
   assign out            = line_buf_q[{addr_buf_q[2 +: OFF_BITS], 5'd0} +: 32];
   assign clk_stall      = clk_stall_q;
   assign readmem        = readmem_q;
   assign mem_block_addr = blk_q;

   icache_tag_store #(
      .WAYS     (WAYS),
      .SETS     (SETS),
      .TAG_BITS (TAG_BITS)
   ) u_tags (
      .clk        (clk),
      .rst_n      (rst_n),
      .lk_idx_i   (lk_idx_s),
      .lk_tag_i   (lk_tag_s),
      .hit_o      (hit_s),
      .hit_way_o  (hit_way_s),
      .victim_o   (victim_s),
      .clear_i    (clear_s),
      .wr_en_i    (wr_en_s),
      .wr_idx_i   (fill_idx_s),
      .wr_way_i   (victim_q),
      .wr_tag_i   (fill_tag_s),
      .lru_en_i   (lru_en_s),
      .lru_idx_i  (lru_idx_s),
      .lru_used_i (lru_used_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; everything freezes while the data cache owns memory
   always_comb begin
      state_d = state_q;
      if (en_s) begin
         case (state_q)
            IDLE:      state_d = flush_now_s ? FLUSH : (hit_s ? IDLE : MISS_WAIT);
            MISS_WAIT: state_d = mem_ready ? IDLE : MISS_WAIT;
            FLUSH:     state_d = IDLE;
            default:   state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Output/datapath next values and tag-store strobes
   always_comb begin
      addr_buf_d   = addr_buf_q;
      line_buf_d   = line_buf_q;
      clk_stall_d  = clk_stall_q;
      readmem_d    = readmem_q;
      blk_d        = blk_q;
      victim_d     = victim_q;
      flush_pend_d = flush_pend_q;
      clear_s      = 1'b0;
      wr_en_s      = 1'b0;
      lru_en_s     = 1'b0;
      lru_idx_s    = lk_idx_s;
      lru_used_s   = hit_way_s;
      if (en_s) begin
         case (state_q)
            IDLE: begin
               if (flush_now_s) begin
                  clear_s      = 1'b1;
                  clk_stall_d  = 1'b1;
                  flush_pend_d = 1'b0;
               end else begin
                  addr_buf_d = addr[ADDR_WIDTH-1:2];
                  if (hit_s) begin
                     line_buf_d  = data_q[hit_way_s][lk_idx_s];
                     clk_stall_d = 1'b0;
                     lru_en_s    = 1'b1;
                  end else begin
                     clk_stall_d = 1'b1;
                     readmem_d   = 1'b1;
                     blk_d       = addr[ADDR_WIDTH-1:2+OFF_BITS];
                     victim_d    = victim_s;
                  end
               end
            end
            MISS_WAIT: begin
               flush_pend_d = flush_pend_q | flush;
               if (mem_ready) begin
                  wr_en_s     = 1'b1;
                  lru_en_s    = 1'b1;
                  lru_idx_s   = fill_idx_s;
                  lru_used_s  = victim_q;
                  line_buf_d  = new_line;
                  readmem_d   = 1'b0;
                  clk_stall_d = 1'b0;
               end else begin
                  readmem_d   = 1'b1;
               end
            end
            FLUSH:   clk_stall_d = 1'b0;
            default: clk_stall_d = 1'b0;
         endcase
      end else begin
         flush_pend_d = flush_pend_q;
      end
   end

   // Datapath and handshake registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_buf_q   <= '0;
         line_buf_q   <= '0;
         clk_stall_q  <= 1'b0;
         readmem_q    <= 1'b0;
         blk_q        <= '0;
         victim_q     <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         addr_buf_q   <= addr_buf_d;
         line_buf_q   <= line_buf_d;
         clk_stall_q  <= clk_stall_d;
         readmem_q    <= readmem_d;
         blk_q        <= blk_d;
         victim_q     <= victim_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   // Line data array: no reset needed, contents are qualified by valid bits
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         data_q[victim_q][fill_idx_s] <= new_line;
      end
   end

endmodule

// File: tb/tb_instruction_cache_assoc.sv
// Directed plus randomized bench for instruction_cache_assoc against a recency-list cache model.
module tb_instruction_cache_assoc;

   localparam int WAYS = 2;
   localparam int SETS = 8;
   localparam int LW   = 8;
   localparam int AW   = 14;

   logic          clk = 1'b0;
   logic          rst_n, flush, mem_ready, data_cache_busy;
   logic [31:0]   addr, out;
   logic          clk_stall, readmem;
   logic [8:0]    mem_block_addr;
   logic [255:0]  new_line;

   int            vectors = 0;
   int            miscompares = 0;
   int            m_tag [SETS][WAYS];
   int            m_cnt [SETS];
   logic [31:0]   last_word;

   always #5 clk = ~clk;

   instruction_cache_assoc #(
      .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .out(out), .clk_stall(clk_stall),
      .flush(flush), .mem_block_addr(mem_block_addr), .readmem(readmem),
      .mem_ready(mem_ready), .new_line(new_line), .data_cache_busy(data_cache_busy)
   );

   // Instruction memory image: word at word-address wa
   function automatic logic [31:0] mem_word(input int wa);
      return 32'h100 + 32'(wa) - 32'h10;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
   endtask

   // Each set holds up to WAYS tags, most recently used first
   task automatic model_access(input logic [31:0] a, output bit hit);
      int s;
      int t;
      int pos;
      s   = int'(a[7:5]);
      t   = int'(a[13:8]);
      pos = -1;
      for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) pos = i;
      hit = (pos >= 0);
      if (!hit) begin
         if (m_cnt[s] < WAYS) m_cnt[s]++;
         pos = m_cnt[s] - 1;
      end
      for (int i = pos; i > 0; i--) m_tag[s][i] = m_tag[s][i-1];
      m_tag[s][0] = t;
   endtask

   task automatic lookup(input logic [31:0] a, output bit hit);
      int n;
      addr = a;
      n = 0;
      for (int w = 0; w < WAYS; w++)
         if (dut.u_tags.valid_q[w][a[7:5]] && dut.u_tags.tag_q[w][a[7:5]] == a[13:8]) n++;
      check("single_way_hit", 32'(n <= 1), 32'd1);
      model_access(a, hit);
      @(posedge clk); #1;
      if (hit) begin
         check("hit_stall", 32'(clk_stall), 32'd0);
         check("hit_readmem", 32'(readmem), 32'd0);
         check("hit_word", out, mem_word(int'(a[13:2])));
         last_word = mem_word(int'(a[13:2]));
      end else begin
         check("miss_stall", 32'(clk_stall), 32'd1);
         check("miss_readmem", 32'(readmem), 32'd1);
         check("miss_blk", 32'(mem_block_addr), 32'(a[13:5]));
      end
   endtask

   task automatic serve(input logic [31:0] a, input int lat, input bit flush_mid);
      for (int i = 0; i < lat; i++) begin
         if (flush_mid && i == 0) flush = 1'b1;
         @(posedge clk); #1;
         flush = 1'b0;
         check("wait_readmem", 32'(readmem), 32'd1);
         check("wait_stall", 32'(clk_stall), 32'd1);
         check("wait_blk", 32'(mem_block_addr), 32'(a[13:5]));
      end
      for (int i = 0; i < LW; i++) new_line[i*32 +: 32] = mem_word(int'(a[13:5]) * LW + i);
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      check("fill_stall", 32'(clk_stall), 32'd0);
      check("fill_readmem", 32'(readmem), 32'd0);
      check("fill_word", out, mem_word(int'(a[13:2])));
      last_word = mem_word(int'(a[13:2]));
   endtask

   task automatic fetch(input logic [31:0] a, input int lat);
      bit hit;
      lookup(a, hit);
      if (!hit) serve(a, lat, 1'b0);
   endtask

   task automatic flush_cycles(input bit drive);
      if (drive) flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_stall_set", 32'(clk_stall), 32'd1);
      check("flush_readmem", 32'(readmem), 32'd0);
      check("flush_out_hold", out, last_word);
      @(posedge clk); #1;
      check("flush_stall_clr", 32'(clk_stall), 32'd0);
      model_clear();
   endtask

   initial begin
      bit          hit;
      bit          fm;
      int          r;
      logic [31:0] a;
      rst_n = 1'b1; flush = 1'b0; mem_ready = 1'b0; data_cache_busy = 1'b0;
      addr = 32'h0; new_line = '0; last_word = 32'h0;
      model_clear();
      #1 rst_n = 1'b0;
      #12;
      check("rst_stall", 32'(clk_stall), 32'd0);
      check("rst_readmem", 32'(readmem), 32'd0);
      check("rst_blk", 32'(mem_block_addr), 32'd0);
      check("rst_out", out, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Cold miss then hit in the same line
      fetch(32'h40, 2);
      fetch(32'h44, 0);
      check("line_word1", out, 32'h101);
      // LRU eviction within set 2
      fetch(32'h1040, 1);
      fetch(32'h2040, 0);
      lookup(32'h1040, hit);
      check("lru_keeps_mru", 32'(hit), 32'd1);
      lookup(32'h40, hit);
      check("lru_evicted", 32'(hit), 32'd0);
      serve(32'h40, 1, 1'b0);
      // Flush in IDLE
      flush_cycles(1'b1);
      lookup(32'h40, hit);
      check("post_flush_miss", 32'(hit), 32'd0);
      serve(32'h40, 0, 1'b0);
      // Flush during a fill
      flush_cycles(1'b1);
      lookup(32'h40, hit);
      serve(32'h40, 2, 1'b1);
      flush_cycles(1'b0);
      lookup(32'h40, hit);
      check("pend_flush_miss", 32'(hit), 32'd0);
      serve(32'h40, 1, 1'b0);
      // data_cache_busy freezes IDLE but not an active miss
      data_cache_busy = 1'b1;
      addr = 32'h80;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("busy_no_readmem", 32'(readmem), 32'd0);
         check("busy_stall_hold", 32'(clk_stall), 32'd0);
         check("busy_out_hold", out, last_word);
      end
      data_cache_busy = 1'b0;
      lookup(32'h80, hit);
      data_cache_busy = 1'b1;
      serve(32'h80, 2, 1'b0);
      @(posedge clk); #1;
      check("busy_after_fill", 32'(readmem), 32'd0);
      check("busy_after_out", out, last_word);
      data_cache_busy = 1'b0;
      // Asynchronous reset mid-miss
      lookup(32'h3100, hit);
      #2 rst_n = 1'b0;
      #1;
      check("arst_readmem", 32'(readmem), 32'd0);
      check("arst_stall", 32'(clk_stall), 32'd0);
      check("arst_out", out, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      model_clear();
      last_word = 32'h0;
      lookup(32'h80, hit);
      check("post_rst_miss", 32'(hit), 32'd0);
      serve(32'h80, 0, 1'b0);

      // Randomized fetch stream over a small tag/index pool
      for (int k = 0; k < 150; k++) begin
         r = int'($urandom_range(0, 15));
         if (r == 0) begin
            flush_cycles(1'b1);
         end else begin
            a = ($urandom & 32'hFFFF_C000) | ($urandom_range(0, 2) << 8) |
                ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            lookup(a, hit);
            if (!hit) begin
               fm = (r == 1);
               serve(a, fm ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3)), fm);
               if (fm) flush_cycles(1'b0);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
